// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, holds the word for decode.
// state | meaning
// REQ   | request for pc offered to imem, waiting for acceptance
// WAIT  | request accepted, waiting for the response (dropped if kill is set)
// HOLD  | instruction presented to decode until consumed or redirected
module cpu_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   imem_req_vld,
   input  logic                   imem_req_rdy,
   output logic [DATA_WIDTH-1:0]  imem_addr,
   input  logic                   imem_rsp_vld,
   input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
   input  logic                   stall,
   input  logic                   redirect_vld,
   input  logic [DATA_WIDTH-1:0]  redirect_pc,
   output logic                   instr_vld,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0]  instr_pc,
   output logic [DATA_WIDTH-1:0]  instr_pc_plus4,
   output logic                   misalign_err
);

   fetch_state_t           state_q, state_d;
   logic [DATA_WIDTH-1:0]  pc_q, pc_d;
   logic                   kill_q, kill_d;
   logic                   req_vld_q, req_vld_d;
   logic                   instr_vld_q, instr_vld_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0]  instr_pc_q, instr_pc_d;
   logic                   misalign_q, misalign_d;
   logic [DATA_WIDTH-1:0]  redir_pc;
   logic [DATA_WIDTH-1:0]  pc_plus4;

   assign redir_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
   assign pc_plus4 = pc_q + DATA_WIDTH'(4);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_d      = kill_q;
      instr_vld_d = instr_vld_q;
      instr_d     = instr_q;
      instr_pc_d  = instr_pc_q;
      misalign_d  = redirect_vld && (redirect_pc[1:0] != 2'b00);

      case (state_q)
         REQ: begin
            // req_vld_q gates acceptance so the first cycle out of reset issues nothing
            if (req_vld_q && imem_req_rdy) begin
               state_d = WAIT;
               if (redirect_vld) begin
                  kill_d = 1'b1;
                  pc_d   = redir_pc;
               end
            end else if (redirect_vld) begin
               pc_d = redir_pc;
            end
         end
         WAIT: begin
            if (redirect_vld) begin
               pc_d = redir_pc;
               if (imem_rsp_vld) begin
                  kill_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  kill_d = 1'b1;
               end
            end else if (imem_rsp_vld) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  instr_d     = imem_rsp_data;
                  instr_pc_d  = pc_q;
                  instr_vld_d = 1'b1;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_vld) begin
               pc_d        = redir_pc;
               instr_vld_d = 1'b0;
               state_d     = REQ;
            end else if (!stall) begin
               pc_d        = pc_plus4;
               instr_vld_d = 1'b0;
               state_d     = REQ;
            end
         end
         default: begin
            state_d = REQ;
         end
      endcase

      req_vld_d = (state_d == REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= REQ;
         pc_q        <= RESET_PC;
         kill_q      <= 1'b0;
         req_vld_q   <= 1'b0;
         instr_vld_q <= 1'b0;
         instr_q     <= NOP_INSTR;
         instr_pc_q  <= RESET_PC;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_q      <= kill_d;
         req_vld_q   <= req_vld_d;
         instr_vld_q <= instr_vld_d;
         instr_q     <= instr_d;
         instr_pc_q  <= instr_pc_d;
         misalign_q  <= misalign_d;
      end
   end

   assign imem_req_vld   = req_vld_q;
   assign imem_addr      = pc_q;
   assign instr_vld      = instr_vld_q;
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign instr_pc_plus4 = instr_pc_q + DATA_WIDTH'(4);
   assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: cycle table for the straight-line path,
// hand sequences for redirect, wrap and reset; request and instruction scoreboards.
module tb_cpu_fetch_unit;
   import cpu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        imem_req_vld;
   logic        imem_req_rdy;
   logic [31:0] imem_addr;
   logic        imem_rsp_vld;
   logic [31:0] imem_rsp_data;
   logic        stall;
   logic        redirect_vld;
   logic [31:0] redirect_pc;
   logic        instr_vld;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
   logic        misalign_err;

   cpu_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_vld   (imem_req_vld),
      .imem_req_rdy   (imem_req_rdy),
      .imem_addr      (imem_addr),
      .imem_rsp_vld   (imem_rsp_vld),
      .imem_rsp_data  (imem_rsp_data),
      .stall          (stall),
      .redirect_vld   (redirect_vld),
      .redirect_pc    (redirect_pc),
      .instr_vld      (instr_vld),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_pc_plus4 (instr_pc_plus4),
      .misalign_err   (misalign_err)
   );

   typedef struct {
      logic        rdy;
      logic        stall;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_ipc;
   } vec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   vec_t        vecs [20];
   logic [31:0] addr_q [$];
   exp_t        exp_q [$];
   int          n_chk;
   int          n_fail;
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_cnt;
   int          lat;
   logic        prev_iv;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t, required finish before 200000", $time);
      $fatal(1);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5EED_0013;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic push_fetch(input logic [31:0] a);
      addr_q.push_back(a);
      exp_q.push_back('{pc: a, word: mem_word(a)});
   endtask

   // One clock: memory model and monitor act at the falling edge, return 1 unit after the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      imem_rsp_vld = 1'b0;
      if (pend) begin
         if (pend_cnt <= 1) begin
            imem_rsp_vld  = 1'b1;
            imem_rsp_data = mem_word(pend_addr);
            pend          = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
      if (imem_req_vld && imem_req_rdy) begin
         if (addr_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_addr: unexpected request at %h, expected no request", imem_addr);
         end else begin
            chk("req_addr", imem_addr, addr_q.pop_front());
         end
         pend      = 1'b1;
         pend_addr = imem_addr;
         pend_cnt  = lat;
      end
      if (instr_vld && !prev_iv) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL instr_present: unexpected instr_pc %h, expected no instruction", instr_pc);
         end else begin
            e = exp_q.pop_front();
            chk("sb_instr_pc", instr_pc, e.pc);
            chk("sb_instr", instr, e.word);
         end
      end
      prev_iv = instr_vld;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_instr();
      for (int k = 0; k < 20 && !instr_vld; k++) tick();
      chk("wait_instr_vld", 32'(instr_vld), 32'd1);
   endtask

   task automatic wait_req();
      for (int k = 0; k < 20 && !imem_req_vld; k++) tick();
      chk("wait_req_vld", 32'(imem_req_vld), 32'd1);
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      pend = 1'b0;
      pend_addr = '0;
      pend_cnt = 0;
      lat = 1;
      prev_iv = 1'b0;
      rst_n = 1'b0;
      imem_req_rdy = 1'b0;
      imem_rsp_vld = 1'b0;
      imem_rsp_data = '0;
      stall = 1'b0;
      redirect_vld = 1'b0;
      redirect_pc = '0;

      vecs = '{
         '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0},
         '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0},
         '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0},
         '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0},
         '{1'b1, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0},
         '{1'b1, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0},
         '{1'b1, 1'b1, 1'b0, 32'h4, 1'b1, 32'h4},
         '{1'b1, 1'b1, 1'b0, 32'h4, 1'b1, 32'h4},
         '{1'b1, 1'b1, 1'b0, 32'h4, 1'b1, 32'h4},
         '{1'b1, 1'b1, 1'b0, 32'h4, 1'b1, 32'h4},
         '{1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'h4},
         '{1'b1, 1'b0, 1'b1, 32'h8, 1'b0, 32'h4},
         '{1'b1, 1'b0, 1'b0, 32'h8, 1'b0, 32'h4},
         '{1'b1, 1'b0, 1'b0, 32'h8, 1'b1, 32'h8},
         '{1'b0, 1'b0, 1'b1, 32'hC, 1'b0, 32'h8}
      };

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_vld", 32'(imem_req_vld), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr_vld", 32'(instr_vld), 32'd0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_pc_plus4", instr_pc_plus4, 32'h4);
      chk("rst_misalign", 32'(misalign_err), 32'd0);
      rst_n = 1'b1;

      // straight-line fetch, rdy held low in REQ, stall held in HOLD
      push_fetch(32'h0);
      push_fetch(32'h4);
      push_fetch(32'h8);
      for (int i = 0; i < 20; i++) begin
         imem_req_rdy = vecs[i].rdy;
         stall        = vecs[i].stall;
         chk($sformatf("row%0d_req_vld", i), 32'(imem_req_vld), 32'(vecs[i].e_rv));
         chk($sformatf("row%0d_addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("row%0d_instr_vld", i), 32'(instr_vld), 32'(vecs[i].e_iv));
         chk($sformatf("row%0d_instr_pc", i), instr_pc, vecs[i].e_ipc);
         if (vecs[i].e_iv) chk($sformatf("row%0d_instr", i), instr, mem_word(vecs[i].e_ipc));
         tick();
      end

      // redirect to 0x100 while waiting; the late 0xC response must be dropped
      lat = 3;
      addr_q.push_back(32'hC);
      push_fetch(32'h100);
      imem_req_rdy = 1'b1;
      tick();
      chk("wait_req_vld_low", 32'(imem_req_vld), 32'd0);
      imem_req_rdy = 1'b0;
      redirect_vld = 1'b1;
      redirect_pc  = 32'h100;
      tick();
      redirect_vld = 1'b0;
      chk("kill_still_waiting", 32'(imem_req_vld), 32'd0);
      chk("aligned_no_misalign", 32'(misalign_err), 32'd0);
      wait_req();
      chk("redir_addr", imem_addr, 32'h100);
      lat = 1;
      imem_req_rdy = 1'b1;
      wait_instr();
      chk("redir_instr_pc", instr_pc, 32'h100);
      chk("redir_pc_plus4", instr_pc_plus4, 32'h104);
      chk("redir_instr", instr, mem_word(32'h100));

      // misaligned redirect while stalled in HOLD
      stall        = 1'b1;
      imem_req_rdy = 1'b0;
      redirect_vld = 1'b1;
      redirect_pc  = 32'h102;
      tick();
      redirect_vld = 1'b0;
      stall        = 1'b0;
      chk("hold_redir_instr_vld", 32'(instr_vld), 32'd0);
      chk("misalign_pulse", 32'(misalign_err), 32'd1);
      chk("hold_redir_req_vld", 32'(imem_req_vld), 32'd1);
      chk("hold_redir_addr", imem_addr, 32'h100);
      tick();
      chk("misalign_one_cycle", 32'(misalign_err), 32'd0);
      chk("hold_redir_addr2", imem_addr, 32'h100);

      // PC wrap past 0xFFFF_FFFC
      redirect_vld = 1'b1;
      redirect_pc  = 32'hFFFF_FFFC;
      tick();
      redirect_vld = 1'b0;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_no_misalign", 32'(misalign_err), 32'd0);
      push_fetch(32'hFFFF_FFFC);
      imem_req_rdy = 1'b1;
      wait_instr();
      chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
      chk("wrap_pc_plus4", instr_pc_plus4, 32'h0);
      imem_req_rdy = 1'b0;
      tick();
      chk("wrap_next_req_vld", 32'(imem_req_vld), 32'd1);
      chk("wrap_next_addr", imem_addr, 32'h0);

      // asynchronous reset while a request to 0x204 is outstanding
      redirect_vld = 1'b1;
      redirect_pc  = 32'h200;
      tick();
      redirect_vld = 1'b0;
      push_fetch(32'h200);
      imem_req_rdy = 1'b1;
      wait_instr();
      chk("pre_rst_instr_pc", instr_pc, 32'h200);
      addr_q.push_back(32'h204);
      tick();
      tick();
      chk("pre_rst_waiting", 32'(imem_req_vld), 32'd0);
      chk("pre_rst_addr", imem_addr, 32'h204);
      rst_n = 1'b0;
      #1;
      chk("midrst_req_vld", 32'(imem_req_vld), 32'd0);
      chk("midrst_addr", imem_addr, 32'h0);
      chk("midrst_instr_vld", 32'(instr_vld), 32'd0);
      chk("midrst_instr", instr, 32'h0000_0013);
      chk("midrst_instr_pc", instr_pc, 32'h0);
      chk("midrst_pc_plus4", instr_pc_plus4, 32'h4);
      chk("midrst_misalign", 32'(misalign_err), 32'd0);
      pend         = 1'b0;
      imem_rsp_vld = 1'b0;
      imem_req_rdy = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rel_req_vld_first", 32'(imem_req_vld), 32'd0);
      tick();
      chk("rel_req_vld", 32'(imem_req_vld), 32'd1);
      chk("rel_addr", imem_addr, 32'h0);

      chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
